// File: rtl/stream_sel_rr_if.sv
// Bundled channel/output handshake signals for stream_sel_rr.
// The SEL_ERR wire exists only when STREAM_SEL_ERR_EN is defined.
interface stream_sel_rr_if #(
    parameter int unsigned CH = 4,
    parameter int unsigned W  = 2,
    parameter int unsigned SW = 2
);
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;

`ifdef STREAM_SEL_ERR_EN
    logic            sel_err;

    // Selector side
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out, out_ch, out_valid, sel_err
    );

    // Producer/consumer side
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out, out_ch, out_valid, sel_err
    );
`else
    // Selector side
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out, out_ch, out_valid
    );

    // Producer/consumer side
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out, out_ch, out_valid
    );
`endif
endinterface

// File: rtl/stream_sel_rr.sv
// CH-way stream selector (fixed select or round-robin) onto one registered output.
// Optional sticky out-of-range select flag: define STREAM_SEL_ERR_EN.
module stream_sel_rr #(
    parameter int unsigned CH = 4,
    parameter int unsigned W  = 2,
    parameter int unsigned SW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_sel_rr_if.slave bus
);
    localparam int unsigned NSEL = 1 << SW;

    logic [NSEL-1:0] sel_oh;
    logic [CH-1:0]   fix_grant;
    logic [CH-1:0]   rr_grant;
    logic [CH-1:0]   grant;
    logic [CH-1:0]   ready;
    logic [CH-1:0]   xfer;
    logic [2*CH-1:0] valid2;
    logic [2*CH-1:0] grant2;
    logic [CH-1:0]   rot_valid;
    logic [CH-1:0]   rot_first;
    logic [SW:0]     shamt;
    logic            space;
    logic            any_xfer;
    logic [W-1:0]    xfer_data;
    logic [SW-1:0]   xfer_ch;

    logic [SW-1:0]   rr_ptr;
    logic [W-1:0]    out_q;
    logic [SW-1:0]   out_ch_q;
    logic            out_valid_q;

    // Fixed select: out-of-range indices fall off the top and yield no grant
    always_comb begin
        sel_oh    = NSEL'(1) << bus.sel;
        fix_grant = sel_oh[CH-1:0];
    end

    // Round-robin: rotate valids so rr_ptr+1 sits at bit 0, take lowest set, rotate back
    always_comb begin
        shamt     = {1'b0, rr_ptr} + (SW+1)'(1);
        valid2    = {bus.in_valid, bus.in_valid};
        rot_valid = CH'(valid2 >> shamt);
        rot_first = rot_valid & (~rot_valid + CH'(1));
        grant2    = {rot_first, rot_first} << shamt;
        rr_grant  = grant2[2*CH-1:CH];
    end

    // OUT_READY reaches IN_READY combinationally so a draining word can be refilled in the same cycle
    always_comb begin
        grant    = bus.mode ? rr_grant : fix_grant;
        space    = ~out_valid_q | bus.out_ready;
        ready    = grant & {CH{space}};
        xfer     = ready & bus.in_valid;
        any_xfer = |xfer;
    end

    // Data mux and channel encode from the one-hot transfer vector
    always_comb begin
        xfer_data = '0;
        xfer_ch   = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (xfer[i]) begin
                xfer_data = xfer_data | bus.in_data[i*W +: W];
                xfer_ch   = xfer_ch | SW'(i);
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr      <= SW'(CH - 1);
        end else if (any_xfer) begin
            out_q       <= xfer_data;
            out_ch_q    <= xfer_ch;
            out_valid_q <= 1'b1;
            rr_ptr      <= xfer_ch;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out       = out_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

`ifdef STREAM_SEL_ERR_EN
    logic sel_ok;
    logic sel_err_q;

    assign sel_ok = |fix_grant;

    // Sticky until reset: fixed mode pointed outside the channel range while someone was valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (!bus.mode && !sel_ok && (|bus.in_valid)) begin
            sel_err_q <= 1'b1;
        end
    end

    assign bus.sel_err = sel_err_q;
`endif

endmodule
